// File: rtl/ahb_mgr_pkg.sv
// Shared types for the AHB-Lite USB endpoint manager: transfer encodings,
// manager FSM states and the captured request record.
package ahb_mgr_pkg;

    localparam int AHB_ADDR_W = 4;
    localparam int AHB_DATA_W = 32;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'd0,
        HTRANS_BUSY   = 2'd1,
        HTRANS_NONSEQ = 2'd2,
        HTRANS_SEQ    = 2'd3
    } htrans_t;

    localparam logic [2:0] HSIZE_BYTE    = 3'd0;
    localparam logic [2:0] HSIZE_HALF    = 3'd1;
    localparam logic [2:0] HSIZE_WORD    = 3'd2;
    localparam logic [2:0] HBURST_SINGLE = 3'd0;

    typedef enum logic [2:0] {
        MGR_IDLE      = 3'd0,
        MGR_ADDR      = 3'd1,
        MGR_ADDR_DATA = 3'd2,
        MGR_DATA      = 3'd3,
        MGR_ERR2      = 3'd4
    } mgr_state_t;

    typedef struct packed {
        logic                  write;
        logic [AHB_ADDR_W-1:0] addr;
        logic [1:0]            size;
        logic [AHB_DATA_W-1:0] wdata;
    } req_t;

    function automatic logic state_has_addr(input mgr_state_t s);
        return (s == MGR_ADDR) || (s == MGR_ADDR_DATA);
    endfunction

    function automatic logic state_has_data(input mgr_state_t s);
        return (s == MGR_ADDR_DATA) || (s == MGR_DATA) || (s == MGR_ERR2);
    endfunction

    function automatic logic [2:0] to_hsize(input logic [1:0] size);
        case (size)
            2'd0:    return HSIZE_BYTE;
            2'd1:    return HSIZE_HALF;
            2'd2:    return HSIZE_WORD;
            default: return {1'b0, size};
        endcase
    endfunction

endpackage

// File: rtl/ahb_mgr_resp_queue.sv
// Two-entry in-order response queue: the output register plus one holding
// slot, so an errored transfer and its cancelled follower issue back to back.
module ahb_mgr_resp_queue #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push_valid,
    input  logic              push_error,
    input  logic [DATA_W-1:0] push_rdata,
    input  logic              push2_valid,
    output logic              rsp_valid,
    output logic              rsp_error,
    output logic [DATA_W-1:0] rsp_rdata
);

    logic              held_valid_r;
    logic              held_error_r;
    logic [DATA_W-1:0] held_rdata_r;
    logic              rsp_valid_r;
    logic              rsp_error_r;
    logic [DATA_W-1:0] rsp_rdata_r;

    // Oldest entry goes out first; the second push (always an error) waits a cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            held_valid_r <= 1'b0;
            held_error_r <= 1'b0;
            held_rdata_r <= {DATA_W{1'b0}};
            rsp_valid_r  <= 1'b0;
            rsp_error_r  <= 1'b0;
            rsp_rdata_r  <= {DATA_W{1'b0}};
        end else if (held_valid_r) begin
            rsp_valid_r  <= 1'b1;
            rsp_error_r  <= held_error_r;
            rsp_rdata_r  <= held_rdata_r;
            held_valid_r <= push_valid;
            held_error_r <= push_error;
            held_rdata_r <= push_rdata;
        end else begin
            rsp_valid_r  <= push_valid;
            rsp_error_r  <= push_error;
            rsp_rdata_r  <= push_rdata;
            held_valid_r <= push2_valid;
            held_error_r <= 1'b1;
            held_rdata_r <= {DATA_W{1'b0}};
        end
    end

    assign rsp_valid = rsp_valid_r;
    assign rsp_error = rsp_error_r;
    assign rsp_rdata = rsp_rdata_r;

endmodule

// File: rtl/ahb_lite_usb_manager.sv
// AHB-Lite single-transfer manager for the USB endpoint subordinate port.
// Optional hready-stall abort is enabled by defining AHB_MGR_TIMEOUT_EN.
module ahb_lite_usb_manager
    import ahb_mgr_pkg::*;
#(
    parameter int ADDR_W         = AHB_ADDR_W,
    parameter int DATA_W         = AHB_DATA_W,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [1:0]        req_size,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_error,
    output logic              hsel,
    output logic [ADDR_W-1:0] haddr,
    output logic [1:0]        htrans,
    output logic [2:0]        hsize,
    output logic              hwrite,
    output logic [DATA_W-1:0] hwdata,
    output logic [2:0]        hburst,
    input  logic [DATA_W-1:0] hrdata,
    input  logic              hresp,
    input  logic              hready
);

    mgr_state_t        state_r;
    logic              cancel_r;
    req_t              pend_r;
    logic              hsel_r;
    htrans_t           htrans_r;
    logic [DATA_W-1:0] hwdata_r;
    logic              d_write_r;

    req_t              req_s;
    logic              a_s;
    logic              d_s;
    logic              req_ready_s;
    logic              accept_s;
    logic              err1_s;
    logic              drop_addr_s;
    logic              tmo_hit_s;
    logic              push_valid_s;
    logic              push_error_s;
    logic [DATA_W-1:0] push_rdata_s;
    logic              push2_valid_s;

    assign a_s         = state_has_addr(state_r);
    assign d_s         = state_has_data(state_r);
    assign req_ready_s = !rst && ((state_r == MGR_IDLE) || (a_s && hready && !hresp));
    assign accept_s    = req_valid && req_ready_s;
    // First error cycle only counts for a live data phase, not while in ERR2.
    assign err1_s      = d_s && (state_r != MGR_ERR2) && hresp && !hready;
    assign drop_addr_s = a_s && (hready || err1_s || tmo_hit_s);

    assign req_s.write = req_write;
    assign req_s.addr  = AHB_ADDR_W'(req_addr);
    assign req_s.size  = req_size;
    assign req_s.wdata = AHB_DATA_W'(req_wdata);

`ifdef AHB_MGR_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0] tmo_cnt_r;

    // Counts consecutive stalled cycles while any transfer is in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_cnt_r <= {TMO_W{1'b0}};
        end else if (hready || tmo_hit_s || !(a_s || d_s)) begin
            tmo_cnt_r <= {TMO_W{1'b0}};
        end else begin
            tmo_cnt_r <= tmo_cnt_r + TMO_W'(1);
        end
    end

    assign tmo_hit_s = !hready && (a_s || d_s) && (tmo_cnt_r == TMO_W'(TIMEOUT_CYCLES - 1));
`else
    // The stall limit has no effect here; the manager waits for hready forever.
    assign tmo_hit_s = (TIMEOUT_CYCLES < 0);
`endif

    // Responses to enqueue this cycle, oldest transfer first.
    always_comb begin
        push_valid_s  = 1'b0;
        push_error_s  = 1'b0;
        push_rdata_s  = {DATA_W{1'b0}};
        push2_valid_s = 1'b0;
        if (tmo_hit_s) begin
            push_valid_s  = a_s || d_s;
            push_error_s  = 1'b1;
            push2_valid_s = a_s && d_s;
        end else if (state_r == MGR_ERR2) begin
            if (hready) begin
                push_valid_s  = 1'b1;
                push_error_s  = 1'b1;
                push2_valid_s = cancel_r;
            end else begin
                push_valid_s  = 1'b0;
            end
        end else if (((state_r == MGR_ADDR_DATA) || (state_r == MGR_DATA)) && hready) begin
            push_valid_s = 1'b1;
            push_error_s = hresp;
            push_rdata_s = (d_write_r || hresp) ? {DATA_W{1'b0}} : hrdata;
        end else begin
            push_valid_s = 1'b0;
        end
    end

    // Pipeline FSM: state encodes the address/data phase flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r  <= MGR_IDLE;
            cancel_r <= 1'b0;
        end else if (tmo_hit_s) begin
            state_r  <= MGR_IDLE;
            cancel_r <= 1'b0;
        end else begin
            case (state_r)
                MGR_IDLE: begin
                    state_r <= accept_s ? MGR_ADDR : MGR_IDLE;
                end
                MGR_ADDR: begin
                    if (hready) begin
                        state_r <= accept_s ? MGR_ADDR_DATA : MGR_DATA;
                    end
                end
                MGR_ADDR_DATA: begin
                    if (err1_s) begin
                        state_r  <= MGR_ERR2;
                        cancel_r <= 1'b1;
                    end else if (hready) begin
                        state_r <= accept_s ? MGR_ADDR_DATA : MGR_DATA;
                    end
                end
                MGR_DATA: begin
                    if (err1_s) begin
                        state_r  <= MGR_ERR2;
                        cancel_r <= 1'b0;
                    end else if (hready) begin
                        state_r <= MGR_IDLE;
                    end
                end
                MGR_ERR2: begin
                    if (hready) begin
                        state_r  <= MGR_IDLE;
                        cancel_r <= 1'b0;
                    end
                end
                default: begin
                    state_r  <= MGR_IDLE;
                    cancel_r <= 1'b0;
                end
            endcase
        end
    end

    // Address-phase outputs; they hold through wait states.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hsel_r   <= 1'b0;
            htrans_r <= HTRANS_IDLE;
            pend_r   <= '{default: 1'b0};
        end else if (accept_s) begin
            hsel_r   <= 1'b1;
            htrans_r <= HTRANS_NONSEQ;
            pend_r   <= req_s;
        end else if (drop_addr_s) begin
            hsel_r   <= 1'b0;
            htrans_r <= HTRANS_IDLE;
        end
    end

    // Data-phase write data follows the address phase that just completed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hwdata_r  <= {DATA_W{1'b0}};
            d_write_r <= 1'b0;
        end else if (a_s && hready) begin
            hwdata_r  <= DATA_W'(pend_r.wdata);
            d_write_r <= pend_r.write;
        end
    end

    ahb_mgr_resp_queue #(
        .DATA_W (DATA_W)
    ) u_resp_queue (
        .clk         (clk),
        .rst         (rst),
        .push_valid  (push_valid_s),
        .push_error  (push_error_s),
        .push_rdata  (push_rdata_s),
        .push2_valid (push2_valid_s),
        .rsp_valid   (rsp_valid),
        .rsp_error   (rsp_error),
        .rsp_rdata   (rsp_rdata)
    );

    assign req_ready = req_ready_s;
    assign hsel      = hsel_r;
    assign htrans    = htrans_r;
    assign haddr     = ADDR_W'(pend_r.addr);
    assign hsize     = to_hsize(pend_r.size);
    assign hwrite    = pend_r.write;
    assign hwdata    = hwdata_r;
    assign hburst    = HBURST_SINGLE;

endmodule

// File: tb/tb_ahb_lite_usb_manager.sv
// Directed table-driven bench for ahb_lite_usb_manager plus reset and
// stuck-hready sequences (timeout behaviour follows AHB_MGR_TIMEOUT_EN).
module tb_ahb_lite_usb_manager;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [3:0]  req_addr;
    logic [1:0]  req_size;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_error;
    logic        hsel;
    logic [3:0]  haddr;
    logic [1:0]  htrans;
    logic [2:0]  hsize;
    logic        hwrite;
    logic [31:0] hwdata;
    logic [2:0]  hburst;
    logic [31:0] hrdata;
    logic        hresp;
    logic        hready;

    ahb_lite_usb_manager #(
        .ADDR_W         (4),
        .DATA_W         (32),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_size  (req_size),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_error (rsp_error),
        .hsel      (hsel),
        .haddr     (haddr),
        .htrans    (htrans),
        .hsize     (hsize),
        .hwrite    (hwrite),
        .hwdata    (hwdata),
        .hburst    (hburst),
        .hrdata    (hrdata),
        .hresp     (hresp),
        .hready    (hready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rv;
        logic        rw;
        logic [3:0]  ra;
        logic [1:0]  rs;
        logic [31:0] wd;
        logic        hr;
        logic        hp;
        logic [31:0] hrd;
        logic        e_ready;
        logic        e_hsel;
        logic [1:0]  e_htrans;
        logic [3:0]  e_haddr;
        logic [2:0]  e_hsize;
        logic        e_hwrite;
        logic [31:0] e_hwdata;
        logic        e_rv;
        logic        e_re;
        logic [31:0] e_rd;
    } vec_t;

    vec_t vq[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic add(input logic rv, input logic rw, input logic [3:0] ra, input logic [1:0] rs,
                       input logic [31:0] wd, input logic hr, input logic hp, input logic [31:0] hrd,
                       input logic e_ready, input logic e_hsel, input logic [1:0] e_htrans,
                       input logic [3:0] e_haddr, input logic [2:0] e_hsize, input logic e_hwrite,
                       input logic [31:0] e_hwdata, input logic e_rv, input logic e_re,
                       input logic [31:0] e_rd);
        vec_t v;
        v.rv = rv; v.rw = rw; v.ra = ra; v.rs = rs; v.wd = wd; v.hr = hr; v.hp = hp; v.hrd = hrd;
        v.e_ready = e_ready; v.e_hsel = e_hsel; v.e_htrans = e_htrans; v.e_haddr = e_haddr;
        v.e_hsize = e_hsize; v.e_hwrite = e_hwrite; v.e_hwdata = e_hwdata;
        v.e_rv = e_rv; v.e_re = e_re; v.e_rd = e_rd;
        vq.push_back(v);
    endtask

    task automatic drive(input logic rv, input logic rw, input logic [3:0] ra, input logic [1:0] rs,
                         input logic [31:0] wd, input logic hr, input logic hp, input logic [31:0] hrd);
        req_valid = rv; req_write = rw; req_addr = ra; req_size = rs; req_wdata = wd;
        hready = hr; hresp = hp; hrdata = hrd;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int pulses;
        int first_k;
        logic first_err;

        // rv rw ra rs wd hr hp hrd | ready hsel htrans haddr hsize hwrite hwdata rsp_v rsp_e rsp_d
        // single write 0xDEADBEEF
        add(1'b1,1'b1,4'h0,2'd2,32'hDEADBEEF,1'b1,1'b0,32'h0, 1'b1,1'b1,2'd2,4'h0,3'd2,1'b1,32'h00000000,1'b0,1'b0,32'h0);
        add(1'b0,1'b0,4'h0,2'd0,32'h0,1'b1,1'b0,32'h0,        1'b1,1'b0,2'd0,4'h0,3'd2,1'b1,32'hDEADBEEF,1'b0,1'b0,32'h0);
        add(1'b0,1'b0,4'h0,2'd0,32'h0,1'b1,1'b0,32'hFFFFFFFF, 1'b0,1'b0,2'd0,4'h0,3'd2,1'b1,32'hDEADBEEF,1'b1,1'b0,32'h0);
        // back-to-back reads 0x4, 0x8
        add(1'b1,1'b0,4'h4,2'd2,32'h0,1'b1,1'b0,32'h0,        1'b1,1'b1,2'd2,4'h4,3'd2,1'b0,32'hDEADBEEF,1'b0,1'b0,32'h0);
        add(1'b1,1'b0,4'h8,2'd2,32'h0,1'b1,1'b0,32'h0,        1'b1,1'b1,2'd2,4'h8,3'd2,1'b0,32'h00000000,1'b0,1'b0,32'h0);
        add(1'b0,1'b0,4'h0,2'd0,32'h0,1'b1,1'b0,32'h12,       1'b1,1'b0,2'd0,4'h8,3'd2,1'b0,32'h00000000,1'b1,1'b0,32'h12);
        add(1'b0,1'b0,4'h0,2'd0,32'h0,1'b1,1'b0,32'h34,       1'b0,1'b0,2'd0,4'h8,3'd2,1'b0,32'h00000000,1'b1,1'b0,32'h34);
        // byte write 0xA5 with one address wait and three data waits
        add(1'b1,1'b1,4'hC,2'd0,32'hA5,1'b1,1'b0,32'h0,       1'b1,1'b1,2'd2,4'hC,3'd0,1'b1,32'h00000000,1'b0,1'b0,32'h0);
        add(1'b0,1'b0,4'h0,2'd0,32'h0,1'b0,1'b0,32'h0,        1'b0,1'b1,2'd2,4'hC,3'd0,1'b1,32'h00000000,1'b0,1'b0,32'h0);
        add(1'b0,1'b0,4'h0,2'd0,32'h0,1'b1,1'b0,32'h0,        1'b1,1'b0,2'd0,4'hC,3'd0,1'b1,32'h000000A5,1'b0,1'b0,32'h0);
        for (int i = 0; i < 3; i++)
            add(1'b0,1'b0,4'h0,2'd0,32'h0,1'b0,1'b0,32'h0,    1'b0,1'b0,2'd0,4'hC,3'd0,1'b1,32'h000000A5,1'b0,1'b0,32'h0);
        add(1'b0,1'b0,4'h0,2'd0,32'h0,1'b1,1'b0,32'h99,       1'b0,1'b0,2'd0,4'hC,3'd0,1'b1,32'h000000A5,1'b1,1'b0,32'h0);
        // error on first of two pipelined requests
        add(1'b1,1'b1,4'h1,2'd2,32'h11111111,1'b1,1'b0,32'h0, 1'b1,1'b1,2'd2,4'h1,3'd2,1'b1,32'h000000A5,1'b0,1'b0,32'h0);
        add(1'b1,1'b0,4'h2,2'd1,32'h0,1'b1,1'b0,32'h0,        1'b1,1'b1,2'd2,4'h2,3'd1,1'b0,32'h11111111,1'b0,1'b0,32'h0);
        add(1'b0,1'b0,4'h0,2'd0,32'h0,1'b0,1'b1,32'h0,        1'b0,1'b0,2'd0,4'h2,3'd1,1'b0,32'h11111111,1'b0,1'b0,32'h0);
        add(1'b0,1'b0,4'h0,2'd0,32'h0,1'b1,1'b1,32'h0,        1'b0,1'b0,2'd0,4'h2,3'd1,1'b0,32'h11111111,1'b1,1'b1,32'h0);
        add(1'b0,1'b0,4'h0,2'd0,32'h0,1'b1,1'b0,32'h0,        1'b1,1'b0,2'd0,4'h2,3'd1,1'b0,32'h11111111,1'b1,1'b1,32'h0);
        // recovery read
        add(1'b1,1'b0,4'h3,2'd2,32'h0,1'b1,1'b0,32'h0,        1'b1,1'b1,2'd2,4'h3,3'd2,1'b0,32'h11111111,1'b0,1'b0,32'h0);
        add(1'b0,1'b0,4'h0,2'd0,32'h0,1'b1,1'b0,32'h0,        1'b1,1'b0,2'd0,4'h3,3'd2,1'b0,32'h00000000,1'b0,1'b0,32'h0);
        add(1'b0,1'b0,4'h0,2'd0,32'h0,1'b1,1'b0,32'hCAFE0001, 1'b0,1'b0,2'd0,4'h3,3'd2,1'b0,32'h00000000,1'b1,1'b0,32'hCAFE0001);
        // hresp without a data phase is ignored (idle, then address-only phase)
        add(1'b0,1'b0,4'h0,2'd0,32'h0,1'b1,1'b1,32'h0,        1'b1,1'b0,2'd0,4'h3,3'd2,1'b0,32'h00000000,1'b0,1'b0,32'h0);
        add(1'b1,1'b0,4'h5,2'd2,32'h0,1'b1,1'b0,32'h0,        1'b1,1'b1,2'd2,4'h5,3'd2,1'b0,32'h00000000,1'b0,1'b0,32'h0);
        add(1'b0,1'b0,4'h0,2'd0,32'h0,1'b1,1'b1,32'h0,        1'b0,1'b0,2'd0,4'h5,3'd2,1'b0,32'h00000000,1'b0,1'b0,32'h0);
        add(1'b0,1'b0,4'h0,2'd0,32'h0,1'b1,1'b0,32'h55,       1'b0,1'b0,2'd0,4'h5,3'd2,1'b0,32'h00000000,1'b1,1'b0,32'h55);

        rst = 1'b1;
        drive(1'b0,1'b0,4'h0,2'd0,32'h0,1'b0,1'b0,32'h0);
        repeat (2) @(posedge clk);
        #1;
        chk("reset req_ready", {31'd0, req_ready}, 32'd0);
        chk("reset hsel", {31'd0, hsel}, 32'd0);
        chk("reset htrans", {30'd0, htrans}, 32'd0);
        chk("reset haddr", {28'd0, haddr}, 32'd0);
        chk("reset hwdata", hwdata, 32'd0);
        chk("reset rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("hburst", {29'd0, hburst}, 32'd0);
        rst = 1'b0;
        #1;

        for (int i = 0; i < vq.size(); i++) begin
            drive(vq[i].rv, vq[i].rw, vq[i].ra, vq[i].rs, vq[i].wd, vq[i].hr, vq[i].hp, vq[i].hrd);
            #1;
            chk($sformatf("row%0d req_ready", i), {31'd0, req_ready}, {31'd0, vq[i].e_ready});
            step();
            chk($sformatf("row%0d hsel", i), {31'd0, hsel}, {31'd0, vq[i].e_hsel});
            chk($sformatf("row%0d htrans", i), {30'd0, htrans}, {30'd0, vq[i].e_htrans});
            chk($sformatf("row%0d haddr", i), {28'd0, haddr}, {28'd0, vq[i].e_haddr});
            chk($sformatf("row%0d hsize", i), {29'd0, hsize}, {29'd0, vq[i].e_hsize});
            chk($sformatf("row%0d hwrite", i), {31'd0, hwrite}, {31'd0, vq[i].e_hwrite});
            chk($sformatf("row%0d hwdata", i), hwdata, vq[i].e_hwdata);
            chk($sformatf("row%0d rsp_valid", i), {31'd0, rsp_valid}, {31'd0, vq[i].e_rv});
            chk($sformatf("row%0d rsp_error", i), {31'd0, rsp_error}, {31'd0, vq[i].e_re});
            chk($sformatf("row%0d rsp_rdata", i), rsp_rdata, vq[i].e_rd);
        end

        // Reset while in ADDR_DATA: outputs clear at once, no responses afterwards.
        drive(1'b1,1'b0,4'h6,2'd2,32'h0,1'b1,1'b0,32'h0);
        step();
        drive(1'b1,1'b0,4'h7,2'd2,32'h0,1'b1,1'b0,32'h0);
        step();
        chk("pre-reset htrans", {30'd0, htrans}, 32'd2);
        chk("pre-reset haddr", {28'd0, haddr}, 32'd7);
        req_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("midreset htrans", {30'd0, htrans}, 32'd0);
        chk("midreset hsel", {31'd0, hsel}, 32'd0);
        chk("midreset haddr", {28'd0, haddr}, 32'd0);
        chk("midreset req_ready", {31'd0, req_ready}, 32'd0);
        pulses = 0;
        repeat (2) begin
            step();
            if (rsp_valid) pulses++;
        end
        rst = 1'b0;
        repeat (4) begin
            step();
            if (rsp_valid) pulses++;
        end
        chk("post-reset rsp pulses", pulses, 32'd0);
        drive(1'b1,1'b1,4'h9,2'd2,32'h5A5A5A5A,1'b1,1'b0,32'h0);
        step();
        chk("after-reset htrans", {30'd0, htrans}, 32'd2);
        chk("after-reset haddr", {28'd0, haddr}, 32'd9);
        req_valid = 1'b0;
        step();
        chk("after-reset hwdata", hwdata, 32'h5A5A5A5A);
        step();
        chk("after-reset rsp_valid", {31'd0, rsp_valid}, 32'd1);
        chk("after-reset rsp_error", {31'd0, rsp_error}, 32'd0);

        // hready stuck low during an address phase.
        drive(1'b1,1'b1,4'hA,2'd2,32'h1,1'b1,1'b0,32'h0);
        step();
        req_valid = 1'b0;
        hready = 1'b0;
        pulses = 0;
        first_k = 0;
        first_err = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            step();
            if (rsp_valid) begin
                pulses++;
                if (first_k == 0) begin
                    first_k = k;
                    first_err = rsp_error;
                end
            end
        end
`ifdef AHB_MGR_TIMEOUT_EN
        chk("timeout response cycle", first_k, 32'd8);
        chk("timeout rsp_error", {31'd0, first_err}, 32'd1);
        chk("timeout rsp pulses", pulses, 32'd1);
        chk("timeout htrans", {30'd0, htrans}, 32'd0);
        chk("timeout hsel", {31'd0, hsel}, 32'd0);
`else
        chk("stall rsp pulses", pulses, 32'd0);
        chk("stall htrans held", {30'd0, htrans}, 32'd2);
        chk("stall haddr held", {28'd0, haddr}, 32'd10);
        chk("stall req_ready", {31'd0, req_ready}, 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
